// File: rtl/prog_loader.sv
// UART boot loader: receives a length-prefixed image over 8N1 serial, writes it to RAM from
// address 0 and holds the CPU in reset until complete. Define PROG_LOADER_CHECKSUM_EN for a trailing checksum byte.
module prog_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       load_req,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_we,
    output logic       cpu_reset,
    output logic       done,
    output logic       error
);
    localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_BITS  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_LEN   = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK = 3'd2;
`endif
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    logic       rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0] rx_state_q, rx_state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_valid, frame_err;

    logic [2:0] state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [8:0] rem_q, rem_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       mem_we_q, mem_we_d;
    logic       cpu_reset_q, cpu_reset_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] check_total;
    assign check_total = sum_q + shift_q;
`endif

    // Receiver: every sample point is taken from the synchronized line.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = 8'd0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = 8'd0;
                    bit_idx_d  = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RX_BITS: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = 8'd0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    byte_valid = rx_sync_q;
                    frame_err  = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
        if (load_req) begin
            rx_state_d = RX_IDLE;
            cnt_d      = 8'd0;
        end
    end

    // Loader: load_req has priority over any byte arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = 1'b0;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        if (load_req) begin
            state_d     = ST_LEN;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
        end else if (frame_err && (state_q != ST_RUN) && (state_q != ST_ERR)) begin
            state_d     = ST_ERR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
        end else if (byte_valid) begin
            case (state_q)
                ST_LEN: begin
                    rem_d   = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                    addr_d  = 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = shift_q;
                    addr_d     = addr_q + 8'd1;
                    rem_d      = rem_q - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + shift_q;
                    if (rem_q == 9'd1) state_d = ST_CHECK;
`else
                    if (rem_q == 9'd1) begin
                        state_d     = ST_RUN;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (check_total == 8'd0) begin
                        state_d     = ST_RUN;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            cnt_q       <= 8'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            state_q     <= ST_LEN;
            addr_q      <= 8'd0;
            rem_q       <= 9'd0;
            mem_addr_q  <= 8'd0;
            mem_data_q  <= 8'd0;
            mem_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_we    = mem_we_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives 8N1 frames on rx and checks RAM writes and CPU release.
module tb_prog_loader;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       load_req = 1'b0;
    logic [7:0] mem_addr, mem_data;
    logic       mem_we, cpu_reset, done, error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int fall_cyc = -1;
    int base;
    int bad;
    logic cpu_reset_prev = 1'b1;
    logic [7:0] wr_addr [0:1023];
    logic [7:0] wr_data [0:1023];
    int         wr_cyc  [0:1023];

    prog_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .load_req(load_req),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write log sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            if (wr_cnt < 1024) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_data;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt++;
        end
        if (cpu_reset_prev && !cpu_reset) fall_cyc = cyc;
        cpu_reset_prev = cpu_reset;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        wait_clks(1);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = stop_bit;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(2 * CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic finish_image(input logic [7:0] s);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00 - s);
`else
        if (s === 8'hxx) wait_clks(1);
        wait_clks(1);
`endif
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        wait_clks(1);
        load_req = 1'b0;
        wait_clks(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " cpu_reset"}, cpu_reset, 1);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_data"}, mem_data, 0);
        check({tag, " done"}, done, 0);
        check({tag, " error"}, error, 0);
    endtask

    initial begin
        wait_clks(3);
        check_reset_values("reset");
        reset = 1'b1;
        wait_clks(2 * CPB);

        // Basic 3-byte image
        send_byte(8'h03);
        send_byte(8'hA1);
        send_byte(8'hB2);
        check("pre cpu_reset", cpu_reset, 1);
        check("pre done", done, 0);
        send_byte(8'hC3);
        finish_image(8'h16);
        check("img1 writes", wr_cnt, 3);
        check("img1 w0", {wr_addr[0], wr_data[0]}, 16'h00A1);
        check("img1 w1", {wr_addr[1], wr_data[1]}, 16'h01B2);
        check("img1 w2", {wr_addr[2], wr_data[2]}, 16'h02C3);
        check("img1 cpu_reset", cpu_reset, 0);
        check("img1 done", done, 1);
        check("img1 error", error, 0);
`ifndef PROG_LOADER_CHECKSUM_EN
        check("img1 release cycle", fall_cyc, wr_cyc[2]);
`endif
        check("img1 addr hold", mem_addr, 8'h02);
        check("img1 data hold", mem_data, 8'hC3);

        // Bytes and framing errors in RUN are ignored
        send_byte(8'h5A);
        send_frame(8'h00, 1'b0);
        check("run ignore writes", wr_cnt, 3);
        check("run ignore done", done, 1);
        check("run ignore error", error, 0);

        // load_req from RUN
        pulse_load();
        check("reload cpu_reset", cpu_reset, 1);
        check("reload done", done, 0);

        // Single-cycle glitch in idle
        rx = 1'b0;
        wait_clks(1);
        rx = 1'b1;
        wait_clks(6 * CPB);
        check("glitch writes", wr_cnt, 3);
        check("glitch error", error, 0);

        // load_req after one of three data bytes, then fresh image
        send_byte(8'h03);
        send_byte(8'hAA);
        check("partial write", {wr_addr[3], wr_data[3]}, 16'h00AA);
        pulse_load();
        check("abort cpu_reset", cpu_reset, 1);
        check("abort done", done, 0);
        send_byte(8'h01);
        send_byte(8'h55);
        finish_image(8'h55);
        check("img2 writes", wr_cnt, 5);
        check("img2 w0", {wr_addr[4], wr_data[4]}, 16'h0055);
        check("img2 done", done, 1);
        check("img2 cpu_reset", cpu_reset, 0);

        // Framing error during DATA
        pulse_load();
        send_byte(8'h02);
        send_byte(8'h11);
        send_frame(8'h22, 1'b0);
        check("frame error", error, 1);
        check("frame cpu_reset", cpu_reset, 1);
        check("frame done", done, 0);
        check("frame writes", wr_cnt, 6);
        send_byte(8'h33);
        check("err sticky", error, 1);
        check("err no write", wr_cnt, 6);
        pulse_load();
        check("err cleared", error, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum pass then fail
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hD0);
        check("cks ok done", done, 1);
        check("cks ok error", error, 0);
        pulse_load();
        base = wr_cnt;
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hD1);
        check("cks bad error", error, 1);
        check("cks bad cpu_reset", cpu_reset, 1);
        check("cks bad writes", wr_cnt - base, 2);
        pulse_load();
`endif

        // Length 0 means 256 bytes
        base = wr_cnt;
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        finish_image(8'h80);
        check("img256 writes", wr_cnt - base, 256);
        check("img256 first", {wr_addr[base], wr_data[base]}, 16'h0000);
        check("img256 last", {wr_addr[base + 255], wr_data[base + 255]}, 16'hFFFF);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wr_addr[base + i] !== 8'(i) || wr_data[base + i] !== 8'(i)) bad++;
        check("img256 all entries", bad, 0);
        check("img256 done", done, 1);
        send_byte(8'h99);
        check("img256 no extra", wr_cnt - base, 256);

        // Asynchronous reset in the middle of a bit
        wait_clks(1);
        rx = 1'b0;
        wait_clks(CPB + 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        wait_clks(2);
        rx = 1'b1;
        reset = 1'b1;
        wait_clks(2 * CPB);
        base = wr_cnt;
        send_byte(8'h01);
        send_byte(8'h77);
        finish_image(8'h77);
        check("post reset writes", wr_cnt - base, 1);
        check("post reset w0", {wr_addr[base], wr_data[base]}, 16'h0077);
        check("post reset done", done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
